// File: rtl/input_debouncer.sv
// Debounces a noisy single-bit input into a clean level plus one-cycle rise/fall pulses.
// Define INPUT_DEBOUNCER_SYNC2_EN for a two-flop synchronizer; the default is one register stage.
module input_debouncer #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    output logic level,
    output logic rise,
    output logic fall,
    output logic busy
);

`ifdef INPUT_DEBOUNCER_SYNC2_EN
    localparam int SYNC_STAGES = 2;
`else
    localparam int SYNC_STAGES = 1;
`endif

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        LOW      = 2'd0,
        RISE_CHK = 2'd1,
        HIGH     = 2'd2,
        FALL_CHK = 2'd3
    } state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               level_next, rise_next, fall_next;
    logic [SYNC_STAGES-1:0] sync;
    logic               s;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
        end else begin
`ifdef INPUT_DEBOUNCER_SYNC2_EN
            sync <= {sync[0], a};
`else
            sync <= a;
`endif
        end
    end

    assign s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOW;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            level <= level_next;
            rise  <= rise_next;
            fall  <= fall_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        level_next = level;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        case (state)
            LOW: begin
                if (s) begin
                    state_next = RISE_CHK;
                    cnt_next   = CNT_W'(1);
                end else begin
                    cnt_next = '0;
                end
            end
            RISE_CHK: begin
                if (!s) begin
                    state_next = LOW;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = HIGH;
                    level_next = 1'b1;
                    rise_next  = 1'b1;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            HIGH: begin
                if (!s) begin
                    state_next = FALL_CHK;
                    cnt_next   = CNT_W'(1);
                end else begin
                    cnt_next = '0;
                end
            end
            FALL_CHK: begin
                if (s) begin
                    state_next = HIGH;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = LOW;
                    level_next = 1'b0;
                    fall_next  = 1'b1;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = LOW;
                cnt_next   = '0;
            end
        endcase
    end

    assign busy = (state == RISE_CHK) || (state == FALL_CHK);

endmodule

// File: tb/tb_input_debouncer.sv
// Directed self-checking bench for input_debouncer (STABLE_CYCLES=4); follows the
// INPUT_DEBOUNCER_SYNC2_EN macro to pick the expected latency.
module tb_input_debouncer;

`ifdef INPUT_DEBOUNCER_SYNC2_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 1;
`endif
    localparam int STABLE = 4;
    localparam int L = SYNC + STABLE - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a = 1'b0;
    logic level, rise, fall, busy;

    int checks = 0;
    int errors = 0;

    input_debouncer #(.STABLE_CYCLES(STABLE)) dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .level(level),
        .rise (rise),
        .fall (fall),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past one rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called right after `a` changes to `dir`: tick i lands on edge k+i-1.
    task automatic run_edge(input logic dir, input string tag);
        int pulses = 0;
        for (int i = 1; i <= L + 3; i++) begin
            logic busy_exp;
            logic lvl_exp;
            logic pulse_exp;
            tick();
            busy_exp  = (i - 1 >= SYNC) && (i - 1 < L);
            lvl_exp   = (i - 1 >= L) ? dir : ~dir;
            pulse_exp = (i - 1 == L);
            check({tag, "_busy"}, busy, busy_exp);
            check({tag, "_level"}, level, lvl_exp);
            check({tag, "_rise"}, rise, dir ? pulse_exp : 1'b0);
            check({tag, "_fall"}, fall, dir ? 1'b0 : pulse_exp);
            pulses += int'(dir ? rise : fall);
        end
        check({tag, "_pulses"}, pulses, 1);
    endtask

    initial begin
        int rises;
        int falls;
        int rise_edge;
        bit busy_seen;
        logic pattern [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

        // Reset, then a=0 held for 20 cycles.
        rst = 1'b1;
        a   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_outs", {level, rise, fall, busy}, 4'b0000);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_low", {level, rise, fall, busy}, 4'b0000);
        end

        // Clean rise, then clean fall from HIGH.
        a = 1'b1;
        run_edge(1'b1, "rise");
        a = 1'b0;
        run_edge(1'b0, "fall");

        // Three-cycle glitch is discarded.
        busy_seen = 1'b0;
        rises = 0;
        a = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i == 3) a = 1'b0;
            tick();
            busy_seen |= busy;
            rises += int'(rise);
            check("glitch_level", level, 1'b0);
        end
        check("glitch_busy_seen", busy_seen, 1'b1);
        check("glitch_busy_end", busy, 1'b0);
        check("glitch_rises", rises, 0);

        // Bounce 1,1,0,1,1,1,1 then held: count restarts at the 0.
        rises = 0;
        falls = 0;
        rise_edge = -1;
        for (int e = 0; e < 16; e++) begin
            a = (e < 7) ? pattern[e] : 1'b1;
            tick();
            rises += int'(rise);
            falls += int'(fall);
            if (rise && rise_edge < 0) rise_edge = e;
        end
        check("bounce_rises", rises, 1);
        check("bounce_falls", falls, 0);
        check("bounce_rise_edge", rise_edge, 3 + L);
        check("bounce_level", level, 1'b1);

        // Return to LOW, then reset in the middle of a rise qualification.
        a = 1'b0;
        for (int i = 0; i < L + 3; i++) tick();
        check("pre_rst_level", level, 1'b0);
        a = 1'b1;
        for (int i = 0; i < SYNC + 1; i++) tick();
        check("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        check("mid_rst_outs", {level, rise, fall, busy}, 4'b0000);
        tick();
        check("mid_rst_outs2", {level, rise, fall, busy}, 4'b0000);
        rst = 1'b0;
        run_edge(1'b1, "rerise");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/input_debouncer.md
# input_debouncer

- Conditions a noisy, asynchronous single-bit input `a` into a clean level plus single-cycle edge pulses.
- Sits directly upstream of the edge and pulse detectors; its `level` output is the signal they sample.
- A change on `a` is accepted only after it has been stable for a programmable number of consecutive cycles. Shorter glitches are discarded.

## Interface

- `STABLE_CYCLES`, default 4: consecutive sampled cycles the synchronized input must differ from `level` before `level` toggles; legal range >= 2.
- `clk`  input  1  single clock; all logic on posedge.
- `rst`  input  1  synchronous, active-high reset.
- `a`  input  1  raw input; may be asynchronous and bouncy.
- `level`  output  1  debounced registered level.
- `rise`  output  1  one-cycle pulse, high in the cycle `level` goes 0->1.
- `fall`  output  1  one-cycle pulse, high in the cycle `level` goes 1->0.
- `busy`  output  1  high while a candidate transition is being qualified.

## Operation

- Sync stage: `a` passes through SYNC_STAGES flops to produce `s`. SYNC_STAGES is 1 or 2; see Configuration.
- FSM states:
  - LOW: `level`=0.
  - RISE_CHK: `level`=0, qualifying a 1.
  - HIGH: `level`=1.
  - FALL_CHK: `level`=1, qualifying a 0.
- Counter `cnt`, width $clog2(STABLE_CYCLES+1), counts consecutive edges with `s` != `level`.
- Transitions from LOW:
  - `s`=1: go to RISE_CHK, `cnt`<=1.
  - Otherwise stay in LOW, `cnt`<=0.
- Transitions from RISE_CHK:
  - `s`=0 (bounce): go to LOW, `cnt`<=0.
  - `s`=1 and `cnt`==STABLE_CYCLES-1: go to HIGH; `level`<=1, `rise`<=1, `cnt`<=0.
  - `s`=1 otherwise: `cnt`<=`cnt`+1.
- HIGH and FALL_CHK mirror LOW and RISE_CHK with polarity swapped; `fall` pulses on the entry to LOW.
- `busy` is high exactly in RISE_CHK and FALL_CHK (decoded from state).
- `rise` and `fall` are registered:
  - each is high for exactly one cycle per accepted transition;
  - they are never high together;
  - they are never high in consecutive cycles, because a new qualification needs at least STABLE_CYCLES >= 2 edges.
- `cnt` never exceeds STABLE_CYCLES-1 and never wraps.
- Glitch rule: an `s` pulse shorter than STABLE_CYCLES cycles never changes `level` and produces no `rise`/`fall`.
- Bounce rule: any bounce during qualification restarts the count from zero.

## Timing

- Reset values: `level`=0, `rise`=0, `fall`=0, `busy`=0, state=LOW, `cnt`=0, all sync flops 0.
- Reset mid-operation: aborts any qualification and forces the reset values on the next edge; no `rise`/`fall` is produced by reset itself.
- If `a` is held 1 through and after reset, `level` re-qualifies from LOW and produces one `rise`.
- Latency: let edge k be the first edge sampling a new stable value on `a`.
  - `level`, `rise`/`fall` update at edge k + L, where L = SYNC_STAGES + STABLE_CYCLES - 1.
  - Default STABLE_CYCLES=4: L=4 without the macro, L=5 with it.
- `busy` rises at edge k + SYNC_STAGES and falls at edge k + L.
- Simultaneous `rst` and an input change: `rst` wins.

## Configuration

- Macro: `INPUT_DEBOUNCER_SYNC2_EN`.
- Defined: SYNC_STAGES=2, a two-flop metastability synchronizer for truly asynchronous `a`.
- Undefined: SYNC_STAGES=1, a single register stage for inputs already synchronous to `clk`.
- All FSM, counter and pulse behaviour is identical in both builds; only L changes.

## Test plan

- Reset, `a`=0 held 20 cycles -> `level`=0, `rise`=`fall`=`busy`=0 throughout.
- STABLE_CYCLES=4, no macro; `a` 0->1 sampled at edge k and held -> `busy` high from edge k+1; `level`=1 and `rise`=1 for one cycle at edge k+4; `busy`=0 from k+4.
- Same config; `a` 1 for 3 cycles then 0 -> `level` stays 0, no `rise`, `busy` high then low.
- `a` bounce pattern 1,1,0,1,1,1,1 -> count restarts at the 0; `level` rises exactly 4 edges after the final return to 1 is sampled; exactly one `rise`.
- From HIGH, `a`->0 held -> `fall` for one cycle at k+4; `level`=0. Repeat with the macro defined -> same pulses at k+5.
- `rst` asserted during RISE_CHK with `a`=1 held -> outputs return to reset values; after `rst` release, a full L-cycle re-qualification and one `rise`.
